sha256_host_ctrl: RTL and testbench
===================================

// Module: sha256_host_ctrl
// PURPOSE
//  Bus-master driver for the sha256_core byte register map. Accepts one pre-padded 512-bit block
//  over valid/ready, writes it as 64 bytes, starts the core, waits for o_irq, then reads the
//  32 digest bytes and returns a 256-bit digest over valid/ready. Sits between a stream source
//  and the core; single-block hashing only (core restarts from HASH_INIT on every run).
// PARAMETERS
//  TIMEOUT_CYCLES  1000  max cycles spent in WAIT before abort
//  CNT_W           16    width of wait counter (must hold TIMEOUT_CYCLES)
// PORTS
//  i_clk          in   1    clock
//  i_rst_n        in   1    asynchronous reset, active low
//  i_blk_valid    in   1    block offered
//  i_blk_data     in   512  block; byte k = i_blk_data[k*8+:8] goes to core addr k
//  o_blk_ready    out  1    block accepted when valid&ready
//  o_dig_valid    out  1    digest available, held until taken
//  o_dig_data     out  256  digest; byte j = core addr 70+j; word a in [255:224]
//  i_dig_ready    in   1    digest consumed when valid&ready
//  o_busy         out  1    high in any state except IDLE
//  o_err_timeout  out  1    one-cycle pulse when WAIT times out
//  o_core_addr    out  7    to core i_w_addr
//  o_core_data8   out  8    to core i_data8
//  o_core_we      out  1    to core i_we
//  i_core_data8   in   8    from core o_data_mux (combinational, same-cycle read)
//  i_core_irq     in   1    from core o_irq (one-cycle pulse)
// BEHAVIOUR
//  Reset: state IDLE, o_blk_ready=1, o_dig_valid=0, o_dig_data=0, o_busy=0, o_err_timeout=0,
//   o_core_we=0, o_core_addr=65, o_core_data8=0, byte/wait counters=0. Async reset mid-run
//   aborts at once; core is left to finish on its own, next run rewrites everything.
//  States (registered outputs, all core signals driven from flops):
//   IDLE : ready=1, we=0, addr=65. valid&ready -> latch block, byte cnt=0 -> LOAD.
//   LOAD : we=1, addr=cnt, data=block[cnt*8+:8]; cnt 0..63, one byte/cycle; after 63 -> START.
//   START: one cycle we=1, addr=65, data=8'h01 (start bit) -> WAIT, wait cnt=0.
//   WAIT : we=0 (core FSM only advances while we=0), addr=65. i_core_irq=1 -> READ, cnt=0.
//          wait cnt==TIMEOUT_CYCLES-1 without irq -> pulse o_err_timeout, -> IDLE, no digest.
//          irq and timeout in the same cycle: irq wins.
//   READ : we=0, addr=70+cnt; on each edge capture i_core_data8 into o_dig_data[cnt*8+:8];
//          cnt 0..31, after byte 31 -> DONE.
//   DONE : o_dig_valid=1, data stable; valid&i_dig_ready -> IDLE (valid drops next cycle).
//  o_blk_ready=1 only in IDLE; a new block is never taken while a digest is pending.
//  i_core_irq outside WAIT is ignored. Counters saturate/clear per state, no wrap beyond bounds.
//  Latency accept->valid: 1 (latch) + 64 (LOAD) + 1 (START) + W (WAIT, core-dependent) + 32
//   (READ) cycles; o_dig_valid rises the cycle after the last READ capture.
// TESTING
//  1 "abc" block (addr 63=0x61,62=0x62,61=0x63,60=0x80, addr0=0x18, rest 0) with real core ->
//    o_dig_data=ba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad.
//  2 Bus trace: exactly 64 we pulses on addrs 0..63 in order, then one write 0x01 to addr 65,
//    no writes during WAIT/READ, reads on addrs 70..101 in order.
//  3 Backpressure: i_dig_ready=0 for 20 cycles -> o_dig_valid and data held, o_blk_ready=0
//    with i_blk_valid=1; ready=1 -> handshake, IDLE next cycle, new block accepted.
//  4 Core model never raises irq, TIMEOUT_CYCLES=50 -> o_err_timeout single pulse 50 cycles
//    after WAIT entry, back to IDLE, o_dig_valid never asserted.
//  5 Reset asserted at LOAD byte 30 -> next cycle outputs at reset values; following block
//    hashes correctly (digest matches scenario 1).
//  6 Spurious irq pulse during LOAD and READ -> ignored, digest unchanged.

Source files
------------

// File: rtl/sha256_host_ctrl.sv
// Bus-master driver for the sha256_core byte register map: loads one 512-bit block,
// starts the core, waits for its interrupt and reads back the 256-bit digest.
module sha256_host_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_blk_valid,
    input  logic [511:0] i_blk_data,
    output logic         o_blk_ready,
    output logic         o_dig_valid,
    output logic [255:0] o_dig_data,
    input  logic         i_dig_ready,
    output logic         o_busy,
    output logic         o_err_timeout,
    output logic [6:0]   o_core_addr,
    output logic [7:0]   o_core_data8,
    output logic         o_core_we,
    input  logic [7:0]   i_core_data8,
    input  logic         i_core_irq
);

    localparam logic [6:0] CTRL_ADDR   = 7'd65;
    localparam logic [6:0] DIGEST_BASE = 7'd70;

    typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StRead, StDone} state_e;

    state_e             state_q, state_d;
    logic [5:0]         byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [511:0]       block_q, block_d;
    logic [255:0]       dig_data_q, dig_data_d;
    logic               blk_ready_q, blk_ready_d;
    logic               dig_valid_q, dig_valid_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [6:0]         addr_q, addr_d;
    logic [7:0]         data_q, data_d;
    logic               we_q, we_d;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        wait_cnt_d = wait_cnt_q;
        block_d    = block_q;
        dig_data_d = dig_data_q;
        err_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_blk_valid) begin
                    block_d    = i_blk_data;
                    byte_cnt_d = 6'd0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                if (byte_cnt_q == 6'd63) begin
                    byte_cnt_d = 6'd0;
                    state_d    = StStart;
                end else begin
                    byte_cnt_d = byte_cnt_q + 6'd1;
                end
            end
            StStart: begin
                wait_cnt_d = '0;
                state_d    = StWait;
            end
            StWait: begin
                // irq takes priority over a coincident timeout
                if (i_core_irq) begin
                    byte_cnt_d = 6'd0;
                    wait_cnt_d = '0;
                    state_d    = StRead;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d      = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            StRead: begin
                dig_data_d[{byte_cnt_q, 3'b000} +: 8] = i_core_data8;
                if (byte_cnt_q == 6'd31) begin
                    byte_cnt_d = 6'd0;
                    state_d    = StDone;
                end else begin
                    byte_cnt_d = byte_cnt_q + 6'd1;
                end
            end
            StDone: begin
                if (i_dig_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so every core signal comes straight from a flop.
    always_comb begin
        blk_ready_d = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
        dig_valid_d = (state_d == StDone);
        we_d        = 1'b0;
        addr_d      = CTRL_ADDR;
        data_d      = 8'h00;
        case (state_d)
            StLoad: begin
                we_d   = 1'b1;
                addr_d = {1'b0, byte_cnt_d};
                data_d = block_d[{byte_cnt_d, 3'b000} +: 8];
            end
            StStart: begin
                we_d   = 1'b1;
                data_d = 8'h01;
            end
            StRead: addr_d = DIGEST_BASE + {1'b0, byte_cnt_d};
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            byte_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            block_q     <= '0;
            dig_data_q  <= '0;
            blk_ready_q <= 1'b1;
            dig_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= CTRL_ADDR;
            data_q      <= 8'h00;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            block_q     <= block_d;
            dig_data_q  <= dig_data_d;
            blk_ready_q <= blk_ready_d;
            dig_valid_q <= dig_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            we_q        <= we_d;
        end
    end

    assign o_blk_ready   = blk_ready_q;
    assign o_dig_valid   = dig_valid_q;
    assign o_dig_data    = dig_data_q;
    assign o_busy        = busy_q;
    assign o_err_timeout = err_q;
    assign o_core_addr   = addr_q;
    assign o_core_data8  = data_q;
    assign o_core_we     = we_q;

endmodule

// File: tb/tb_sha256_host_ctrl.sv
// Bench for sha256_host_ctrl: behavioural sha256_core model plus scoreboards for the bus
// write trace and the returned digests.
module tb_sha256_host_ctrl;

    localparam int unsigned TIMEOUT = 50;
    localparam int unsigned LAT     = 20;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         blk_valid;
    logic [511:0] blk_data;
    logic         blk_ready;
    logic         dig_valid;
    logic [255:0] dig_data;
    logic         dig_ready;
    logic         busy;
    logic         err_timeout;
    logic [6:0]   core_addr;
    logic [7:0]   core_data8;
    logic         core_we;
    logic [7:0]   core_rdata;
    logic         core_irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [14:0]  exp_wr [$];
    logic [255:0] exp_dig [$];
    logic [6:0]   rd_obs [$];

    sha256_host_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(16)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_blk_valid   (blk_valid),
        .i_blk_data    (blk_data),
        .o_blk_ready   (blk_ready),
        .o_dig_valid   (dig_valid),
        .o_dig_data    (dig_data),
        .i_dig_ready   (dig_ready),
        .o_busy        (busy),
        .o_err_timeout (err_timeout),
        .o_core_addr   (core_addr),
        .o_core_data8  (core_data8),
        .o_core_we     (core_we),
        .i_core_data8  (core_rdata),
        .i_core_irq    (core_irq)
    );

    always #5 clk = ~clk;

    logic [31:0] k_tab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha256_blk(input logic [511:0] m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = m[511 - 32 * t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        a = 32'h6a09e667; b = 32'hbb67ae85; c = 32'h3c6ef372; d = 32'ha54ff53a;
        e = 32'h510e527f; f = 32'h9b05688c; g = 32'h1f83d9ab; h = 32'h5be0cd19;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g))
                 + k_tab[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + 32'h6a09e667, b + 32'hbb67ae85, c + 32'h3c6ef372, d + 32'ha54ff53a,
                e + 32'h510e527f, f + 32'h9b05688c, g + 32'h1f83d9ab, h + 32'h5be0cd19};
    endfunction

    // Core model: byte memory, start at addr 65 bit 0, irq LAT cycles later (we=0 cycles only).
    logic [7:0]   mem [128];
    logic [511:0] msg_live;
    logic [511:0] msg_snap = '0;
    logic [255:0] model_dig;
    logic [7:0]   cd = 8'd0;
    logic         irq_q = 1'b0;
    logic         no_irq = 1'b0;
    logic         spur_irq = 1'b0;

    always_comb begin
        msg_live = '0;
        for (int k = 0; k < 64; k++) msg_live[k*8 +: 8] = mem[k];
    end

    always_comb model_dig = sha256_blk(msg_snap);

    always_comb begin
        int idx;
        idx = int'(core_addr) - 70;
        if (idx >= 0 && idx < 32) core_rdata = model_dig[idx*8 +: 8];
        else                      core_rdata = mem[core_addr];
    end

    assign core_irq = irq_q | spur_irq;

    always @(posedge clk) begin
        irq_q <= 1'b0;
        if (core_we) begin
            mem[core_addr] <= core_data8;
            if (core_addr == 7'd65 && core_data8[0] && !no_irq) begin
                cd       <= 8'(LAT);
                msg_snap <= msg_live;
            end
        end else if (cd != 8'd0) begin
            cd <= cd - 8'd1;
            if (cd == 8'd1) irq_q <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus monitor: every write must match the scoreboard; reads are recorded.
    always @(negedge clk) begin
        if (rst_n && core_we) begin
            if (exp_wr.size() == 0) check("unexpected write", {core_addr, core_data8}, 15'h7fff);
            else                    check("write trace", {core_addr, core_data8}, exp_wr.pop_front());
        end else if (rst_n && core_addr != 7'd65) begin
            rd_obs.push_back(core_addr);
        end
    end

    task automatic offer(input logic [511:0] b, input bit push_dig);
        int n = 0;
        for (int k = 0; k < 64; k++) exp_wr.push_back({7'(k), b[k*8 +: 8]});
        exp_wr.push_back({7'd65, 8'h01});
        if (push_dig) exp_dig.push_back(sha256_blk(b));
        blk_valid = 1'b1;
        blk_data  = b;
        while (!blk_ready && n < 300) begin @(negedge clk); n++; end
        check("accept bound", 256'(n < 300), 256'd1);
        @(negedge clk);
        blk_valid = 1'b0;
    endtask

    task automatic wait_digest(input string tag, output logic [255:0] exp);
        int n = 0;
        while (!dig_valid && n < 1000) begin @(negedge clk); n++; end
        check({tag, " valid bound"}, 256'(n < 1000), 256'd1);
        if (exp_dig.size() == 0) begin
            exp = '0;
            check({tag, " digest expected"}, 256'd0, 256'd1);
        end else begin
            exp = exp_dig.pop_front();
            check({tag, " digest"}, dig_data, exp);
        end
    endtask

    task automatic take(input string tag);
        dig_ready = 1'b1;
        @(negedge clk);
        dig_ready = 1'b0;
        check({tag, " valid drop"}, 256'(dig_valid), 256'd0);
        check({tag, " ready back"}, 256'(blk_ready), 256'd1);
        check({tag, " idle"}, 256'(busy), 256'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " blk_ready"}, 256'(blk_ready), 256'd1);
        check({tag, " dig_valid"}, 256'(dig_valid), 256'd0);
        check({tag, " dig_data"}, dig_data, 256'd0);
        check({tag, " busy"}, 256'(busy), 256'd0);
        check({tag, " err"}, 256'(err_timeout), 256'd0);
        check({tag, " we"}, 256'(core_we), 256'd0);
        check({tag, " addr"}, 256'(core_addr), 256'd65);
        check({tag, " data8"}, 256'(core_data8), 256'd0);
    endtask

    initial begin
        logic [511:0] abc_blk, r1, r2;
        logic [255:0] abc_dig, got_exp, exp6;
        int n;
        bit dv_seen;

        for (int k = 0; k < 128; k++) mem[k] = 8'h00;
        abc_blk = '0;
        abc_blk[511:504] = 8'h61;
        abc_blk[503:496] = 8'h62;
        abc_blk[495:488] = 8'h63;
        abc_blk[487:480] = 8'h80;
        abc_blk[7:0]     = 8'h18;
        abc_dig = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
        for (int i = 0; i < 16; i++) begin
            r1[i*32 +: 32] = $urandom;
            r2[i*32 +: 32] = $urandom;
        end

        rst_n = 1'b0; blk_valid = 1'b0; blk_data = '0; dig_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // abc block: known digest, full write trace, ordered reads
        check("sha model abc", sha256_blk(abc_blk), abc_dig);
        rd_obs.delete();
        offer(abc_blk, 1'b1);
        check("busy in load", 256'(busy), 256'd1);
        wait_digest("abc", got_exp);
        check("abc known digest", dig_data, abc_dig);
        check("read count", 256'(rd_obs.size()), 256'd32);
        for (int i = 0; i < rd_obs.size(); i++) check("read addr", 256'(rd_obs[i]), 256'(70 + i));
        take("abc");

        // spurious irq during LOAD and READ
        offer(r1, 1'b1);
        repeat (5) @(negedge clk);
        spur_irq = 1'b1;
        @(negedge clk);
        spur_irq = 1'b0;
        check("spur load still writing", 256'(core_we), 256'd1);
        n = 0;
        while (!(!core_we && core_addr >= 7'd80 && core_addr != 7'd65) && n < 500) begin
            @(negedge clk); n++;
        end
        check("read phase bound", 256'(n < 500), 256'd1);
        spur_irq = 1'b1;
        @(negedge clk);
        spur_irq = 1'b0;
        wait_digest("spur", exp6);

        // backpressure with a new block offered
        for (int k = 0; k < 64; k++) exp_wr.push_back({7'(k), r2[k*8 +: 8]});
        exp_wr.push_back({7'd65, 8'h01});
        exp_dig.push_back(sha256_blk(r2));
        blk_valid = 1'b1;
        blk_data  = r2;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp valid held", 256'(dig_valid), 256'd1);
            check("bp data held", dig_data, exp6);
            check("bp no accept", 256'(blk_ready), 256'd0);
        end
        dig_ready = 1'b1;
        @(negedge clk);
        dig_ready = 1'b0;
        check("bp valid drop", 256'(dig_valid), 256'd0);
        check("bp idle ready", 256'(blk_ready), 256'd1);
        @(negedge clk);
        blk_valid = 1'b0;
        check("bp new accepted", 256'(busy), 256'd1);
        wait_digest("bp", got_exp);
        take("bp");

        // timeout: core never interrupts
        no_irq = 1'b1;
        rd_obs.delete();
        offer(abc_blk, 1'b0);
        n = 0;
        while (!(core_we && core_addr == 7'd65) && n < 200) begin @(negedge clk); n++; end
        check("start bound", 256'(n < 200), 256'd1);
        n = 0;
        dv_seen = 1'b0;
        while (!err_timeout && n < 300) begin
            @(negedge clk); n++;
            dv_seen = dv_seen | dig_valid;
        end
        check("timeout latency", 256'(n), 256'(TIMEOUT + 1));
        @(negedge clk);
        dv_seen = dv_seen | dig_valid;
        check("timeout pulse width", 256'(err_timeout), 256'd0);
        check("timeout idle", 256'(blk_ready), 256'd1);
        check("timeout no digest", 256'(dv_seen), 256'd0);
        check("timeout no reads", 256'(rd_obs.size()), 256'd0);
        no_irq = 1'b0;

        // async reset in the middle of LOAD
        offer(abc_blk, 1'b0);
        n = 0;
        while (!(core_we && core_addr == 7'd30) && n < 200) begin @(negedge clk); n++; end
        check("load byte 30 bound", 256'(n < 200), 256'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("mid reset");
        exp_wr.delete();
        rst_n = 1'b1;
        @(negedge clk);
        offer(abc_blk, 1'b1);
        wait_digest("post reset", got_exp);
        check("post reset known digest", dig_data, abc_dig);
        take("post reset");
        check("writes drained", 256'(exp_wr.size()), 256'd0);
        check("digests drained", 256'(exp_dig.size()), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
